// File: rtl/cpu_pkg.sv
// Shared definitions for the Harvard no-pipeline CPU.
// Contents:
//    seq_state_t       - sequencer FSM state encoding (IDLE, FETCH, EXEC1, EXEC2)
//    FETCH_B..EXEC2_B  - bit positions of the one-hot phase strobes on `state`
//    INST_W_DEF        - default opcode width, shared by decoder and sequencer
//    OPND_W_DEF        - default operand width, shared by decoder and sequencer
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC1 = 2'd2,
      EXEC2 = 2'd3
   } seq_state_t;

   localparam int FETCH_B = 0;
   localparam int EXEC1_B = 1;
   localparam int EXEC2_B = 2;

   localparam int INST_W_DEF = 4;
   localparam int OPND_W_DEF = 8;

endpackage

// File: rtl/cpu_sequencer.sv
// Timing sequencer and instruction register for the Harvard no-pipeline CPU.
// Fetches one instruction word per instruction through a req/ack handshake,
// then walks two execute phases that can be held by `stall`.
// Ports:
//    clk, rst_n   - clock, asynchronous active-low reset
//    start, stop  - leave IDLE / return to IDLE at the end of EXEC2
//    imem_req     - fetch request (high throughout FETCH)
//    imem_ack     - program memory word valid
//    imem_data    - {opcode, operand}
//    stall        - holds EXEC1/EXEC2
//    state        - one-hot phase strobes {exec2, exec1, fetch}, one cycle each
//    inst/operand - latched instruction fields
//    busy         - not IDLE
//    retired      - completed-instruction count, wraps
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int INST_W = INST_W_DEF,
   parameter int OPND_W = OPND_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     stop,
   output logic                     imem_req,
   input  logic                     imem_ack,
   input  logic [INST_W+OPND_W-1:0] imem_data,
   input  logic                     stall,
   output logic [2:0]               state,
   output logic [INST_W-1:0]        inst,
   output logic [OPND_W-1:0]        operand,
   output logic                     busy,
   output logic [CNT_W-1:0]         retired
);

   seq_state_t fsm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm     <= IDLE;
         inst    <= '0;
         operand <= '0;
         retired <= '0;
      end else begin
         unique case (fsm)
            IDLE: begin
               if (start) fsm <= FETCH;
            end
            FETCH: begin
               if (imem_ack) begin
                  fsm     <= EXEC1;
                  inst    <= imem_data[INST_W+OPND_W-1:OPND_W];
                  operand <= imem_data[OPND_W-1:0];
               end
            end
            EXEC1: begin
               if (!stall) fsm <= EXEC2;
            end
            EXEC2: begin
               if (!stall) begin
                  // stop takes priority over a concurrent start; start is not queued
                  fsm     <= stop ? IDLE : FETCH;
                  retired <= retired + 1'b1;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   // Strobes qualify the FSM state with the handshake/stall so each phase
   // fires exactly one cycle per instruction, however long it is held.
   always_comb begin
      state          = '0;
      state[FETCH_B] = (fsm == FETCH) && imem_ack;
      state[EXEC1_B] = (fsm == EXEC1) && !stall;
      state[EXEC2_B] = (fsm == EXEC2) && !stall;
   end

   assign imem_req = (fsm == FETCH);
   assign busy     = (fsm != IDLE);

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Timing sequencer and instruction register for the Harvard no-pipeline CPU. It drives the control decoder's `state` (one-hot phase strobes) and `inst` (latched opcode) inputs. It paces instruction fetch against program memory with a request/acknowledge handshake, and holds execute phases while data-side logic stalls. Each phase strobe is high for exactly one cycle per instruction, so decoder outputs such as push, pop, WrEn and pc_inc fire exactly once.

## Interface
- `INST_W`, default 4: opcode width, the upper field of the instruction word.
- `OPND_W`, default 8: operand or address field width, the lower field of the instruction word.
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  leaves IDLE; ignored in any other state.
- `stop`  in  1  sampled at EXEC2 completion; if high, returns to IDLE instead of FETCH.
- `imem_req`  out  1  fetch request to program memory.
- `imem_ack`  in  1  program memory word is valid this cycle.
- `imem_data`  in  INST_W+OPND_W  instruction word: {opcode, operand}.
- `stall`  in  1  holds the current execute phase.
- `state`  out  3  one-hot phase strobes: bit0 fetch, bit1 exec1, bit2 exec2.
- `inst`  out  INST_W  latched opcode.
- `operand`  out  OPND_W  latched operand.
- `busy`  out  1  high in any state except IDLE.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- FSM states: IDLE, FETCH, EXEC1, EXEC2.
- The `state` output is a one-hot strobe, not the raw FSM encoding:
  - `state[0] = (FETCH & imem_ack)`
  - `state[1] = (EXEC1 & ~stall)`
  - `state[2] = (EXEC2 & ~stall)`
  - `state` = 000 in IDLE and in every wait or stall cycle.
- Transitions:
  - IDLE: `start` -> FETCH.
  - FETCH: `imem_ack` -> EXEC1, latching `inst`/`operand` from `imem_data`. Otherwise wait in FETCH.
  - EXEC1: `~stall` -> EXEC2. Otherwise hold.
  - EXEC2: `~stall & stop` -> IDLE, `~stall & ~stop` -> FETCH. Otherwise hold.
- `imem_req = (FETCH)`, combinational from the state register. It stays high until acknowledged. `imem_ack` outside FETCH is ignored.
- `inst`/`operand` change only on an acknowledged fetch and stay stable through EXEC1 and EXEC2.
- `retired` increments by 1 on each EXEC2 exit (to FETCH or IDLE). It wraps modulo 2^CNT_W with no saturation and no flag.
- `stall` in FETCH or IDLE has no effect.

## Timing
- Reset (async assert, synchronous deassert handled externally):
  - FSM = IDLE
  - `state` = 000, `imem_req` = 0, `busy` = 0
  - `inst` = 0, `operand` = 0, `retired` = 0
- Minimum instruction time is 3 cycles: FETCH with immediate ack, EXEC1, EXEC2. Each added ack-wait or stall cycle adds 1.
- `start` to first `imem_req`: 1 cycle. `imem_req` is high the cycle after `start` is sampled.
- `inst` is visible in the cycle after the ack cycle, i.e. the first EXEC1 cycle.
- Reset mid-instruction: immediate return to IDLE with all outputs at reset values. A partially fetched word is discarded and `retired` is not incremented.
- `start` and `stop` both high in EXEC2: `stop` wins, FSM goes to IDLE. `start` is not remembered.
- `stop` held high through FETCH or EXEC1 has no effect until EXEC2 completes.

## Structure
- Shared package `cpu_pkg`:
  - FSM state enum (IDLE, FETCH, EXEC1, EXEC2).
  - Phase bit indices: FETCH_B = 0, EXEC1_B = 1, EXEC2_B = 2.
  - Default INST_W/OPND_W constants, so the decoder and sequencer agree.
- Single module. The retire counter is inline; no sub-module is warranted.

## Test plan
- Reset, then `start` for one cycle, `imem_ack` tied high, `imem_data` = 0x5A3 -> `state` sequence 001, 010, 100 repeating, `inst` = 0x5, `operand` = 0xA3 from the first EXEC1, `retired` = 1 after 3 cycles.
- `imem_ack` delayed 4 cycles -> `imem_req` high for 5 cycles, `state` = 000 for 4 cycles then a single 001 cycle.
- `stall` high for 3 cycles in EXEC1 -> `state[1]` asserted exactly once, after `stall` falls; EXEC2 follows the next cycle.
- `stop` high during EXEC2 -> FSM returns to IDLE, `busy` = 0, `imem_req` stays 0 until the next `start`.
- `rst_n` pulsed low during EXEC1 -> all outputs zero immediately; the next `start` refetches cleanly.
- CNT_W = 4, run 17 instructions -> `retired` reads 1 (wrapped).
